board_ctrl: RTL and testbench

Parametrised Minesweeper board controller: owns cursor position, per-tile flag/reveal state, and game status for a GRID_W × GRID_H board. Adds zero-tile flood-fill, win/loss detection, flag counting and restart, none of which the first-generation board logic had. Sits between the board generator (mine map and adjacency counts) and the pixel renderer, which consumes the `revealed`/`flagged` vectors and the cursor coordinates.

---
 rtl/ms_pkg.sv | 20 ++
 rtl/popcount_n.sv | 17 +
 rtl/board_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_board_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_pkg.sv
// rtl/ms_pkg.sv - Shared types and constants for the minesweeper board controller
package ms_pkg;

  typedef enum logic [1:0] {
    GS_PLAY = 2'd0,
    GS_WON  = 2'd1,
    GS_LOST = 2'd2
  } game_state_e;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_e;

  localparam int KEY_RIGHT = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_LEFT  = 3;

endpackage

// File: rtl/popcount_n.sv
// rtl/popcount_n.sv - Combinational population count of a W-bit vector
module popcount_n #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_bits,
  output logic [CW-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/board_ctrl.sv
// rtl/board_ctrl.sv - Minesweeper board controller: cursor, flag/reveal state, flood fill, game status
module board_ctrl
  import ms_pkg::*;
#(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int WRAP   = 0,
  localparam int N  = GRID_W * GRID_H,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(N + 1),
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     keys,
  input  logic           flag_sw,
  input  logic           reveal_sw,
  input  logic           new_game,
  input  logic [N-1:0]   mine_map,
  input  logic [4*N-1:0] adj,
  output logic [XW-1:0]  cur_x,
  output logic [YW-1:0]  cur_y,
  output logic [N-1:0]   revealed,
  output logic [N-1:0]   flagged,
  output logic [CW-1:0]  reveal_count,
  output logic [CW-1:0]  flag_count,
  output logic [1:0]     game_state,
  output logic           busy
);

  logic [3:0]    r_keys_q;
  logic          r_flag_q;
  logic          r_reveal_q;
  logic          r_new_q;
  logic [XW-1:0] r_cur_x;
  logic [YW-1:0] r_cur_y;
  logic [N-1:0]  r_revealed;
  logic [N-1:0]  r_flagged;
  game_state_e   r_game_state;
  fill_state_e   r_fill_state;
  logic [IW-1:0] r_scan_idx;
  logic          r_changed;

  logic [3:0]    w_key_edge;
  logic          w_flag_edge;
  logic          w_reveal_edge;
  logic          w_new_edge;
  logic [XW-1:0] w_cur_x_nxt;
  logic [YW-1:0] w_cur_y_nxt;
  logic [N-1:0]  w_revealed_nxt;
  logic [N-1:0]  w_flagged_nxt;
  game_state_e   w_game_nxt;
  fill_state_e   w_fill_nxt;
  logic [IW-1:0] w_scan_nxt;
  logic          w_changed_nxt;
  logic [N-1:0]  w_adj_zero;
  logic [N-1:0]  w_open;
  logic          w_nbr_open;
  logic          w_fill_hit;
  logic [IW-1:0] w_cur_idx;
  logic [CW-1:0] w_mine_count;
  logic          w_win;

  // Keys are active-low, so a press is "low now, high last cycle".
  assign w_key_edge    = ~keys & r_keys_q;
  assign w_flag_edge   = flag_sw & ~r_flag_q;
  assign w_reveal_edge = reveal_sw & ~r_reveal_q;
  assign w_new_edge    = new_game & ~r_new_q;

  assign w_cur_idx = IW'(int'(r_cur_y) * GRID_W + int'(r_cur_x));

  for (genvar g = 0; g < N; g++) begin : g_adj
    assign w_adj_zero[g] = (adj[4*g +: 4] == 4'd0);
  end
  assign w_open = r_revealed & w_adj_zero;

  popcount_n #(.W(N), .CW(CW)) u_pc_rev  (.i_bits(r_revealed), .o_count(reveal_count));
  popcount_n #(.W(N), .CW(CW)) u_pc_flag (.i_bits(r_flagged),  .o_count(flag_count));
  popcount_n #(.W(N), .CW(CW)) u_pc_mine (.i_bits(mine_map),   .o_count(w_mine_count));

  assign w_win = (reveal_count == CW'(N) - w_mine_count);

  always_comb begin
    w_cur_x_nxt = r_cur_x;
    w_cur_y_nxt = r_cur_y;
    if (w_key_edge[KEY_RIGHT] && !w_key_edge[KEY_LEFT]) begin
      if (r_cur_x != XW'(GRID_W - 1)) w_cur_x_nxt = r_cur_x + XW'(1);
      else if (WRAP != 0)             w_cur_x_nxt = '0;
    end else if (w_key_edge[KEY_LEFT] && !w_key_edge[KEY_RIGHT]) begin
      if (r_cur_x != '0)  w_cur_x_nxt = r_cur_x - XW'(1);
      else if (WRAP != 0) w_cur_x_nxt = XW'(GRID_W - 1);
    end
    if (w_key_edge[KEY_DOWN] && !w_key_edge[KEY_UP]) begin
      if (r_cur_y != YW'(GRID_H - 1)) w_cur_y_nxt = r_cur_y + YW'(1);
      else if (WRAP != 0)             w_cur_y_nxt = '0;
    end else if (w_key_edge[KEY_UP] && !w_key_edge[KEY_DOWN]) begin
      if (r_cur_y != '0)  w_cur_y_nxt = r_cur_y - YW'(1);
      else if (WRAP != 0) w_cur_y_nxt = YW'(GRID_H - 1);
    end
    if (w_new_edge) begin
      w_cur_x_nxt = '0;
      w_cur_y_nxt = '0;
    end
  end

  // Any in-board 8-neighbour of the scanned tile that is revealed with adj == 0.
  always_comb begin
    int sx, sy, nx, ny;
    w_nbr_open = 1'b0;
    sx = int'(r_scan_idx) % GRID_W;
    sy = int'(r_scan_idx) / GRID_W;
    nx = 0;
    ny = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = sx + dx;
        ny = sy + dy;
        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H) begin
          if (w_open[IW'(ny * GRID_W + nx)]) w_nbr_open = 1'b1;
        end
      end
    end
  end

  assign w_fill_hit = !r_revealed[r_scan_idx] && !r_flagged[r_scan_idx] &&
                      !mine_map[r_scan_idx] && w_nbr_open;

  always_comb begin
    w_revealed_nxt = r_revealed;
    w_flagged_nxt  = r_flagged;
    w_game_nxt     = r_game_state;
    w_fill_nxt     = r_fill_state;
    w_scan_nxt     = r_scan_idx;
    w_changed_nxt  = r_changed;
    if (w_new_edge) begin
      w_revealed_nxt = '0;
      w_flagged_nxt  = '0;
      w_game_nxt     = GS_PLAY;
      w_fill_nxt     = FILL_IDLE;
      w_scan_nxt     = '0;
      w_changed_nxt  = 1'b0;
    end else if (r_fill_state == FILL_RUN) begin
      if (w_fill_hit) begin
        w_revealed_nxt[r_scan_idx] = 1'b1;
        w_changed_nxt              = 1'b1;
      end
      if (r_scan_idx == IW'(N - 1)) begin
        w_scan_nxt    = '0;
        w_changed_nxt = 1'b0;
        if (!(r_changed || w_fill_hit)) w_fill_nxt = FILL_IDLE;
      end else begin
        w_scan_nxt = r_scan_idx + IW'(1);
      end
    end else if (r_game_state == GS_PLAY) begin
      if (w_flag_edge) begin
        if (!r_revealed[w_cur_idx]) w_flagged_nxt[w_cur_idx] = ~r_flagged[w_cur_idx];
      end else if (w_reveal_edge && !r_revealed[w_cur_idx] && !r_flagged[w_cur_idx]) begin
        w_revealed_nxt[w_cur_idx] = 1'b1;
        if (mine_map[w_cur_idx]) begin
          w_game_nxt = GS_LOST;
        end else if (w_adj_zero[w_cur_idx]) begin
          w_fill_nxt    = FILL_RUN;
          w_scan_nxt    = '0;
          w_changed_nxt = 1'b0;
        end
      end
      if (w_win) w_game_nxt = GS_WON;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_keys_q     <= 4'hF;
      r_flag_q     <= 1'b0;
      r_reveal_q   <= 1'b0;
      r_new_q      <= 1'b0;
      r_cur_x      <= '0;
      r_cur_y      <= '0;
      r_revealed   <= '0;
      r_flagged    <= '0;
      r_game_state <= GS_PLAY;
      r_fill_state <= FILL_IDLE;
      r_scan_idx   <= '0;
      r_changed    <= 1'b0;
    end else begin
      r_keys_q     <= keys;
      r_flag_q     <= flag_sw;
      r_reveal_q   <= reveal_sw;
      r_new_q      <= new_game;
      r_cur_x      <= w_cur_x_nxt;
      r_cur_y      <= w_cur_y_nxt;
      r_revealed   <= w_revealed_nxt;
      r_flagged    <= w_flagged_nxt;
      r_game_state <= w_game_nxt;
      r_fill_state <= w_fill_nxt;
      r_scan_idx   <= w_scan_nxt;
      r_changed    <= w_changed_nxt;
    end
  end

  assign cur_x      = r_cur_x;
  assign cur_y      = r_cur_y;
  assign revealed   = r_revealed;
  assign flagged    = r_flagged;
  assign game_state = r_game_state;
  assign busy       = (r_fill_state == FILL_RUN);

endmodule

// File: tb/tb_board_ctrl.sv
// tb/tb_board_ctrl.sv - Self-checking bench for board_ctrl on an 8x8 board
module tb_board_ctrl;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = 64;
  localparam int CW = 7;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [3:0]     keys = 4'hF;
  logic           flag_sw = 1'b0;
  logic           reveal_sw = 1'b0;
  logic           new_game = 1'b0;
  logic [N-1:0]   mine_map = '0;
  logic [4*N-1:0] adj = '0;

  logic [2:0]    cur_x, cur_y, cur_x_w, cur_y_w;
  logic [N-1:0]  revealed, flagged, revealed_w, flagged_w;
  logic [CW-1:0] reveal_count, flag_count, reveal_count_w, flag_count_w;
  logic [1:0]    game_state, game_state_w;
  logic          busy, busy_w;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  board_ctrl #(.GRID_W(W), .GRID_H(H), .WRAP(0)) u_dut (
    .clk(clk), .rst(rst), .keys(keys), .flag_sw(flag_sw), .reveal_sw(reveal_sw),
    .new_game(new_game), .mine_map(mine_map), .adj(adj),
    .cur_x(cur_x), .cur_y(cur_y), .revealed(revealed), .flagged(flagged),
    .reveal_count(reveal_count), .flag_count(flag_count),
    .game_state(game_state), .busy(busy)
  );

  board_ctrl #(.GRID_W(W), .GRID_H(H), .WRAP(1)) u_dut_w (
    .clk(clk), .rst(rst), .keys(keys), .flag_sw(flag_sw), .reveal_sw(reveal_sw),
    .new_game(new_game), .mine_map(mine_map), .adj(adj),
    .cur_x(cur_x_w), .cur_y(cur_y_w), .revealed(revealed_w), .flagged(flagged_w),
    .reveal_count(reveal_count_w), .flag_count(flag_count_w),
    .game_state(game_state_w), .busy(busy_w)
  );

  // Game model: whole flood fill resolved at once, DUT timing reduced to a busy countdown.
  logic [3:0]   m_keys_q;
  logic         m_flag_q, m_rev_q, m_new_q;
  int           m_x, m_y, m_xw, m_yw;
  logic [N-1:0] m_rev, m_flag, m_fill_final;
  int           m_state;
  int           m_busy_left;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int popc(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic bit adj_zero(input int i);
    logic [3:0] a;
    a = adj[4*i +: 4];
    return a == 4'd0;
  endfunction

  function automatic bit has_open_nbr(input logic [N-1:0] v, input int i);
    int x = i % W;
    int y = i / W;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
          if (v[(y + dy) * W + x + dx] && adj_zero((y + dy) * W + x + dx)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int run_fill(input logic [N-1:0] start, output logic [N-1:0] fin);
    logic [N-1:0] rv;
    bit changed;
    int passes = 0;
    rv = start;
    do begin
      changed = 1'b0;
      passes++;
      for (int i = 0; i < N; i++)
        if (!rv[i] && !m_flag[i] && !mine_map[i] && has_open_nbr(rv, i)) begin
          rv[i] = 1'b1;
          changed = 1'b1;
        end
    end while (changed);
    fin = rv;
    return passes;
  endfunction

  function automatic int step_axis(input int v, input bit inc, input bit dec, input bit wrap);
    if (inc && !dec) return (v == 7) ? (wrap ? 0 : 7) : v + 1;
    if (dec && !inc) return (v == 0) ? (wrap ? 7 : 0) : v - 1;
    return v;
  endfunction

  task automatic model_reset();
    m_keys_q = 4'hF; m_flag_q = 1'b0; m_rev_q = 1'b0; m_new_q = 1'b0;
    m_x = 0; m_y = 0; m_xw = 0; m_yw = 0;
    m_rev = '0; m_flag = '0; m_fill_final = '0;
    m_state = 0; m_busy_left = 0;
  endtask

  task automatic model_step();
    logic [3:0] ke;
    logic fe, re, ne;
    int idx;
    bit won;
    ke = ~keys & m_keys_q;
    fe = flag_sw & ~m_flag_q;
    re = reveal_sw & ~m_rev_q;
    ne = new_game & ~m_new_q;
    m_keys_q = keys; m_flag_q = flag_sw; m_rev_q = reveal_sw; m_new_q = new_game;
    if (ne) begin
      m_x = 0; m_y = 0; m_xw = 0; m_yw = 0;
      m_rev = '0; m_flag = '0; m_state = 0; m_busy_left = 0;
      return;
    end
    idx = m_y * W + m_x;
    won = (popc(m_rev) == N - popc(mine_map));
    m_x  = step_axis(m_x,  ke[0], ke[3], 1'b0);
    m_y  = step_axis(m_y,  ke[1], ke[2], 1'b0);
    m_xw = step_axis(m_xw, ke[0], ke[3], 1'b1);
    m_yw = step_axis(m_yw, ke[1], ke[2], 1'b1);
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_rev = m_fill_final;
    end else if (m_state == 0) begin
      if (fe) begin
        if (!m_rev[idx]) m_flag[idx] = ~m_flag[idx];
      end else if (re && !m_rev[idx] && !m_flag[idx]) begin
        m_rev[idx] = 1'b1;
        if (mine_map[idx]) m_state = 2;
        else if (adj_zero(idx)) m_busy_left = N * run_fill(m_rev, m_fill_final);
      end
      if (won) m_state = 1;
    end
  endtask

  always @(posedge clk) begin
    if (!rst) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cur_x", 64'(cur_x), 64'(m_x));
      chk("cur_y", 64'(cur_y), 64'(m_y));
      chk("cur_x_wrap", 64'(cur_x_w), 64'(m_xw));
      chk("cur_y_wrap", 64'(cur_y_w), 64'(m_yw));
      chk("busy", 64'(busy), 64'(m_busy_left > 0));
      chk("game_state", 64'(game_state), 64'(m_state));
      chk("flagged", flagged, m_flag);
      chk("flag_count", 64'(flag_count), 64'(popc(m_flag)));
      if (m_busy_left == 0) begin
        chk("revealed", revealed, m_rev);
        chk("reveal_count", 64'(reveal_count), 64'(popc(m_rev)));
      end
    end
  end

  task automatic press_key(input int b);
    @(negedge clk) keys[b] = 1'b0;
    @(negedge clk) keys = 4'hF;
  endtask

  // which: 0 flag, 1 reveal, 2 new game, 3 flag+reveal together
  task automatic pulse(input int which);
    @(negedge clk);
    flag_sw   = (which == 0 || which == 3);
    reveal_sw = (which == 1 || which == 3);
    new_game  = (which == 2);
    @(negedge clk);
    flag_sw = 1'b0; reveal_sw = 1'b0; new_game = 1'b0;
  endtask

  task automatic wait_fill(input string name, input int expect_len);
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk(name, 64'(n), 64'(expect_len));
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cur_x", 64'(cur_x), 64'd0);
    chk("rst_cur_y", 64'(cur_y), 64'd0);
    chk("rst_revealed", revealed, 64'd0);
    chk("rst_flag_count", 64'(flag_count), 64'd0);
    chk("rst_state", 64'(game_state), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    check_en = 1'b1;

    // 1: saturate vs wrap
    press_key(3);
    chk("t1_left_sat", 64'(cur_x), 64'd0);
    chk("t1_left_wrap", 64'(cur_x_w), 64'd7);
    repeat (9) press_key(0);
    chk("t1_right_sat", 64'(cur_x), 64'd7);
    chk("t1_right_wrap", 64'(cur_x_w), 64'd0);
    press_key(2);
    chk("t1_up_wrap", 64'(cur_y_w), 64'd7);

    // 2: flag rules on (2,3) = index 26
    adj = {N{4'h1}};
    pulse(2);
    press_key(0); press_key(0);
    press_key(1); press_key(1); press_key(1);
    pulse(0);
    chk("t2_flag_on", 64'(flagged[26]), 64'd1);
    chk("t2_fcount_1", 64'(flag_count), 64'd1);
    pulse(0);
    chk("t2_flag_off", 64'(flagged[26]), 64'd0);
    chk("t2_fcount_0", 64'(flag_count), 64'd0);
    pulse(0);
    pulse(1);
    chk("t2_rev_flagged", 64'(revealed[26]), 64'd0);
    pulse(0);
    pulse(3);
    chk("t2_both_flag", 64'(flagged[26]), 64'd1);
    chk("t2_both_norev", 64'(revealed[26]), 64'd0);
    pulse(0);
    pulse(1);
    chk("t2_rev", 64'(revealed[26]), 64'd1);
    chk("t2_rcount", 64'(reveal_count), 64'd1);
    pulse(0);
    chk("t2_flag_revealed", 64'(flagged[26]), 64'd0);

    // 3: full fill and win
    mine_map = '0;
    adj = '0;
    pulse(2);
    pulse(1);
    wait_fill("t3_busy_len", 128);
    chk("t3_all_rev", revealed, {N{1'b1}});
    chk("t3_rcount", 64'(reveal_count), 64'd64);
    chk("t3_still_play", 64'(game_state), 64'd0);
    @(negedge clk);
    chk("t3_won", 64'(game_state), 64'd1);
    pulse(0);
    chk("t3_won_noflag", 64'(flag_count), 64'd0);

    // 4: mine loss at index 9
    mine_map = 64'h200;
    adj = {N{4'h1}};
    pulse(2);
    press_key(0); press_key(1);
    pulse(1);
    chk("t4_lost", 64'(game_state), 64'd2);
    chk("t4_rev9", 64'(revealed[9]), 64'd1);
    press_key(0);
    pulse(0);
    pulse(1);
    chk("t4_noflag", 64'(flag_count), 64'd0);
    chk("t4_norev", 64'(reveal_count), 64'd1);
    press_key(3);
    press_key(3);
    chk("t4_cursor_moves", 64'(cur_x), 64'd0);

    // 5: mines in column 4 bound the fill
    mine_map = 64'h1010_1010_1010_1010;
    for (int i = 0; i < N; i++)
      adj[4*i +: 4] = (i % W == 3 || i % W == 5) ? 4'd3 : ((i % W == 4) ? 4'd2 : 4'd0);
    pulse(2);
    pulse(1);
    wait_fill("t5_busy_len", 128);
    chk("t5_cols", revealed, 64'h0F0F_0F0F_0F0F_0F0F);
    @(negedge clk);
    chk("t5_play", 64'(game_state), 64'd0);

    // 6: restart mid-fill, with a reveal during busy and a same-cycle move
    mine_map = '0;
    adj = '0;
    pulse(2);
    pulse(1);
    repeat (20) @(negedge clk);
    press_key(0);
    chk("t6_move_busy", 64'(cur_x), 64'd1);
    chk("t6_busy", 64'(busy), 64'd1);
    pulse(1);
    repeat (3) @(negedge clk);
    new_game = 1'b1;
    keys[0] = 1'b0;
    @(negedge clk);
    new_game = 1'b0;
    keys = 4'hF;
    chk("t6_busy_clr", 64'(busy), 64'd0);
    chk("t6_rev_clr", revealed, 64'd0);
    chk("t6_state", 64'(game_state), 64'd0);
    chk("t6_cur", 64'({cur_y, cur_x}), 64'd0);
    repeat (4) @(negedge clk);

    // 7: asynchronous reset aborts a fill
    pulse(1);
    repeat (10) @(negedge clk);
    check_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("t7_rst_busy", 64'(busy), 64'd0);
    chk("t7_rst_rev", revealed, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    check_en = 1'b1;
    repeat (4) @(negedge clk);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
